wakeup_frame_tx: RTL

//  Parametrised wake-up-triggered frame transmitter: detects a wake-up edge, arms a timeout

---
 rtl/wakeup_frame_tx_pkg.sv | 13 +
 rtl/wakeup_frame_tx_if.sv | 24 ++
 rtl/wakeup_frame_tx_scrambler.sv | 31 +++
 rtl/wakeup_frame_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wakeup_frame_tx_pkg.sv
// Shared state encoding and default scrambler taps for the wake-up frame transmitter.
package wakeup_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TX,
    ST_DONE
  } state_t;

  localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hD9;

endpackage

// File: rtl/wakeup_frame_tx_if.sv
// Front-end inputs and transmit-driver outputs of the wake-up frame transmitter.
interface wakeup_frame_tx_if;
  logic wake_up;
  logic comp_out;
  logic wu_valid;
  logic data_clk_en;
  logic data_clk;
  logic bit_strobe;
  logic t_0;
  logic t_1;
  logic busy;
  logic done;
  logic timeout_err;

  modport master (
    output wake_up, comp_out,
    input  wu_valid, data_clk_en, data_clk, bit_strobe, t_0, t_1, busy, done, timeout_err
  );

  modport slave (
    input  wake_up, comp_out,
    output wu_valid, data_clk_en, data_clk, bit_strobe, t_0, t_1, busy, done, timeout_err
  );
endinterface

// File: rtl/wakeup_frame_tx_scrambler.sv
// Self-synchronising scrambler: the previous output bit is shifted in before the tap parity.
module frame_scrambler
  import wakeup_frame_pkg::*;
#(
  parameter int unsigned          LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = LFSR_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic clki,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d_in,
  input  logic fb_in,
  output logic d_out
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_shift;

  assign w_shift = {r_lfsr[LFSR_W-2:0], fb_in};
  assign d_out   = d_in ^ (^(w_shift & LFSR_TAPS));

  always_ff @(posedge clki) begin
    if (rst || clr) begin
      r_lfsr <= '0;
    end else if (en) begin
      r_lfsr <= w_shift;
    end
  end

endmodule

// File: rtl/wakeup_frame_tx.sv
// Wake-up armed frame transmitter: synchronisers, FSM, arm timer, bit-clock divider
// and bit counter feeding a preamble/payload/tail serialiser.
module wakeup_frame_tx
  import wakeup_frame_pkg::*;
#(
  parameter int unsigned       DIV         = 100,
  parameter int unsigned       CNT_W       = 20,
  parameter int unsigned       TIMEOUT     = 60000,
  parameter int unsigned       START_DELAY = 25342,
  parameter int unsigned       TRIG_MODE   = 0,
  parameter int unsigned       PRE_BITS    = 432,
  parameter int unsigned       PAY_BITS    = 768,
  parameter int unsigned       TAIL_BITS   = 16,
  parameter int unsigned       RUN_LEN     = 4,
  parameter int unsigned       LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = LFSR_W'(DEFAULT_LFSR_TAPS)
) (
  input logic              clki,
  input logic              rst,
  wakeup_frame_tx_if.slave bus
);

  localparam int unsigned     N_BITS     = PRE_BITS + PAY_BITS + TAIL_BITS;
  localparam longint unsigned LIM        = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_SD        = CNT_W'(START_DELAY);
  localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_PRE       = CNT_W'(PRE_BITS);
  localparam logic [CNT_W-1:0] C_PRE_PAY   = CNT_W'(PRE_BITS + PAY_BITS);
  localparam logic [CNT_W-1:0] C_NBITS     = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] C_RUN_LAST  = CNT_W'(RUN_LEN - 1);

  if ((DIV < 2) || (DIV % 2 != 0) || (TIMEOUT < 1) || (RUN_LEN < 1) || (LFSR_W < 2) ||
      (longint'(TIMEOUT) > LIM) || (longint'(START_DELAY) >= LIM) ||
      (longint'(N_BITS) >= LIM) || (longint'(RUN_LEN) > LIM) ||
      (longint'(DIV / 2) > LIM)) begin : g_bad_params
    $error("wakeup_frame_tx: parameter out of range for CNT_W");
  end

  logic r_wake_s1, r_wake_s2, r_wake_dly, r_wake_rise;
  logic r_comp_s1, r_comp_s2, r_comp_dly, r_comp_rise;

  state_t r_state, w_next;
  logic   w_start, w_timeout, w_wrap, w_rise_tick, w_in_pre, w_in_pay, w_scr_out;

  logic [CNT_W-1:0] r_timer, r_div_cnt, r_bit_idx, r_run_cnt;
  logic             r_run_phase, r_data_clk, r_strobe, r_t0, r_t1, r_timeout_err;

  // Edge flags are registered, so an input change reaches the FSM 3 cycles later.
  always_ff @(posedge clki) begin
    if (rst) begin
      {r_wake_s1, r_wake_s2, r_wake_dly, r_wake_rise} <= '0;
      {r_comp_s1, r_comp_s2, r_comp_dly, r_comp_rise} <= '0;
    end else begin
      r_wake_s1   <= bus.wake_up;
      r_wake_s2   <= r_wake_s1;
      r_wake_dly  <= r_wake_s2;
      r_wake_rise <= r_wake_s2 & ~r_wake_dly;
      r_comp_s1   <= bus.comp_out;
      r_comp_s2   <= r_comp_s1;
      r_comp_dly  <= r_comp_s2;
      r_comp_rise <= r_comp_s2 & ~r_comp_dly;
    end
  end

  assign w_wrap      = (r_div_cnt == C_HALF_LAST);
  assign w_rise_tick = (r_state == ST_TX) && w_wrap && !r_data_clk;
  assign w_in_pre    = (r_bit_idx < C_PRE);
  assign w_in_pay    = !w_in_pre && (r_bit_idx < C_PRE_PAY);

  always_ff @(posedge clki) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_wake_rise) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (((TRIG_MODE == 0) && (r_timer == C_SD)) ||
            ((TRIG_MODE != 0) && r_comp_rise && (r_timer >= C_SD))) begin
          w_next  = ST_TX;
          w_start = 1'b1;
        end else if (r_timer == C_TO_LAST) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_TX: begin
        if (w_wrap && r_data_clk && (r_bit_idx == C_NBITS)) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.wu_valid    = (r_state == ST_ARMED);
    bus.busy        = (r_state != ST_IDLE);
    bus.data_clk_en = (r_state == ST_TX);
    bus.done        = (r_state == ST_DONE);
    bus.data_clk    = r_data_clk;
    bus.bit_strobe  = r_strobe;
    bus.t_0         = r_t0;
    bus.t_1         = r_t1;
    bus.timeout_err = r_timeout_err;
  end

  frame_scrambler #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_scrambler (
    .clki  (clki),
    .rst   (rst),
    .clr   (w_rise_tick && w_in_pre),
    .en    (w_rise_tick && w_in_pay),
    .d_in  (~r_run_phase),
    .fb_in (r_t1),
    .d_out (w_scr_out)
  );

  always_ff @(posedge clki) begin
    if (rst) begin
      r_timer       <= '0;
      r_div_cnt     <= '0;
      r_bit_idx     <= '0;
      r_run_cnt     <= '0;
      r_run_phase   <= 1'b0;
      r_data_clk    <= 1'b0;
      r_strobe      <= 1'b0;
      r_t0          <= 1'b0;
      r_t1          <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_strobe      <= 1'b0;
      r_timeout_err <= w_timeout;
      r_timer       <= (r_state == ST_ARMED) ? r_timer + 1'b1 : '0;
      if (w_start) begin
        r_div_cnt   <= '0;
        r_bit_idx   <= '0;
        r_run_cnt   <= '0;
        r_run_phase <= 1'b0;
        r_data_clk  <= 1'b0;
      end else if (r_state == ST_TX) begin
        if (w_wrap) begin
          r_div_cnt  <= '0;
          r_data_clk <= ~r_data_clk;
          if (!r_data_clk) begin
            r_strobe  <= 1'b1;
            r_bit_idx <= r_bit_idx + 1'b1;
            r_t1      <= w_in_pay ? w_scr_out : 1'b0;
            r_t0      <= w_in_pay;
            if (w_in_pay) begin
              // Run counter replaces (p/RUN_LEN)%2 so no divider is needed.
              if (r_run_cnt == C_RUN_LAST) begin
                r_run_cnt   <= '0;
                r_run_phase <= ~r_run_phase;
              end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
              end
            end
          end else if (r_bit_idx == C_NBITS) begin
            r_t1 <= 1'b0;
            r_t0 <= 1'b0;
          end
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end else begin
        r_data_clk <= 1'b0;
        r_t1       <= 1'b0;
        r_t0       <= 1'b0;
      end
    end
  end

endmodule
